// File: rtl/reservoir_pkg.sv
// Shared types and default timing constants for the reservoir run scheduler.
// The FSM state encoding and the sample width live here so the FIFO and top agree.
package reservoir_pkg;

  localparam int SAMPLE_W              = 8;
  localparam int DEFAULT_RUN_CYCLES    = 3201;
  localparam int DEFAULT_SAMPLE_OFFSET = 8;
  localparam int DEFAULT_SAMPLE_STRIDE = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_RUN,
    ST_SEND,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/reservoir_run_scheduler_if.sv
// Push/pop bundle between the scheduler FSM (master) and its input byte FIFO (slave).
interface reservoir_run_scheduler_if;
  import reservoir_pkg::*;

  logic    push_valid;
  sample_t push_data;
  logic    pop;
  sample_t pop_data;
  logic    empty;
  logic    full;
  logic    drop;

  modport master (
    output push_valid, push_data, pop,
    input  pop_data, empty, full, drop
  );

  modport slave (
    input  push_valid, push_data, pop,
    output pop_data, empty, full, drop
  );

endinterface

// File: rtl/byte_fifo.sv
// Circular byte FIFO; a push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module byte_fifo
  import reservoir_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                      clk_i,
  input logic                      rst_i,
  reservoir_run_scheduler_if.slave fifo_if
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  sample_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  assign fifo_if.empty    = (count_q == '0);
  assign fifo_if.full     = (count_q == CNT_W'(DEPTH));
  assign pop              = fifo_if.pop && !fifo_if.empty;
  assign push             = fifo_if.push_valid && (!fifo_if.full || pop);
  assign fifo_if.drop     = fifo_if.push_valid && !push;
  assign fifo_if.pop_data = mem_q[rd_ptr_q];

  // NOTE: every signal gets its hold value first, so no path through this block leaves one unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses <= so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the cleared count already marks every slot as invalid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= fifo_if.push_data;
  end

endmodule

// File: rtl/reservoir_run_scheduler.sv
// Launches one reservoir run per queued byte, samples eight dynamics bits per run
// and hands the packed byte downstream before the run window is allowed to close.
module reservoir_run_scheduler
  import reservoir_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int RUN_CYCLES    = DEFAULT_RUN_CYCLES,
  parameter int SAMPLE_OFFSET = DEFAULT_SAMPLE_OFFSET,
  parameter int SAMPLE_STRIDE = DEFAULT_SAMPLE_STRIDE
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  output logic [7:0] run_byte,
  output logic       acquire,
  input  logic       dynamics,
  output logic [7:0] tx_byte,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int CNT_W = $clog2(RUN_CYCLES + 1);
  localparam int IDX_W = $clog2(SAMPLE_W);

  if (SAMPLE_OFFSET + 7 * SAMPLE_STRIDE >= RUN_CYCLES) begin : g_bad_timing
    $error("reservoir_run_scheduler: last sample point must fall before RUN_CYCLES");
  end

  reservoir_run_scheduler_if fifo_if ();

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (reset),
    .fifo_if (fifo_if)
  );

  assign fifo_if.push_valid = rx_valid;
  assign fifo_if.push_data  = rx_byte;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_sat;
  logic [IDX_W-1:0] idx_q, idx_d;
  sample_t          shift_q, shift_d;
  sample_t          run_byte_q, run_byte_d;
  sample_t          tx_byte_q, tx_byte_d;
  logic             overflow_q;
  logic             sample_hit;

  assign cnt_sat    = (cnt_q < CNT_W'(RUN_CYCLES)) ? cnt_q + 1'b1 : cnt_q;
  assign sample_hit = (cnt_q == CNT_W'(SAMPLE_OFFSET + SAMPLE_STRIDE * int'(idx_q)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    run_byte_d   = run_byte_q;
    tx_byte_d    = tx_byte_q;
    fifo_if.pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_if.empty) begin
          fifo_if.pop = 1'b1;
          run_byte_d  = fifo_if.pop_data;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_sat;
        // Left shift puts the first sample of the run in the MSB after all eight arrive.
        if (sample_hit) begin
          shift_d = {shift_q[SAMPLE_W-2:0], dynamics};
          idx_d   = idx_q + 1'b1;
          if (idx_q == IDX_W'(SAMPLE_W - 1)) begin
            tx_byte_d = {shift_q[SAMPLE_W-2:0], dynamics};
            state_d   = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        cnt_d = cnt_sat;
        if (tx_ready) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_d = cnt_sat;
        if (cnt_q >= CNT_W'(RUN_CYCLES)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      run_byte_q <= '0;
      tx_byte_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      run_byte_q <= run_byte_d;
      tx_byte_q  <= tx_byte_d;
      overflow_q <= overflow_q | fifo_if.drop;
    end
  end

  assign acquire  = (state_q == ST_LAUNCH);
  assign tx_valid = (state_q == ST_SEND);
  assign busy     = (state_q != ST_IDLE);
  assign run_byte = run_byte_q;
  assign tx_byte  = tx_byte_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_reservoir_run_scheduler.sv
// Directed bench for reservoir_run_scheduler: single run, stalled handshake,
// mid-run reset, FIFO overflow ordering and push-during-pop on a full FIFO.
module tb_reservoir_run_scheduler;

  localparam int RUN_CYCLES = 3201;
  localparam int OFFSET     = 8;
  localparam int STRIDE     = 16;
  localparam int MIN_GAP    = RUN_CYCLES + 3;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] rx_byte  = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] run_byte;
  logic       acquire;
  logic       dynamics;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready = 1'b1;
  logic       busy;
  logic       overflow;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         since_acq = 100000;
  logic [7:0] dyn_mask = '0;
  logic [7:0] acq_bytes[$];
  int         acq_cycles[$];

  reservoir_run_scheduler dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .run_byte (run_byte),
    .acquire  (acquire),
    .dynamics (dynamics),
    .tx_byte  (tx_byte),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overflow (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) begin
    cyc       <= cyc + 1;
    since_acq <= (acquire === 1'b1) ? 0 : since_acq + 1;
  end

  // Dynamics is high in a +/-3 cycle window around every sample point whose mask bit is set (bit 7 = k0).
  always_comb begin
    dynamics = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (dyn_mask[7-k] && since_acq >= OFFSET + STRIDE * k - 3 && since_acq <= OFFSET + STRIDE * k + 3)
        dynamics = 1'b1;
    end
  end

  always @(negedge CLOCK_50) begin
    if (acquire === 1'b1) begin
      acq_bytes.push_back(run_byte);
      acq_cycles.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic push(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask

  // which: 0 = acquire high, 1 = tx_valid high, 2 = busy low
  task automatic wait_until(input string tag, input int which, input int limit);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      case (which)
        0:       hit = (acquire === 1'b1);
        1:       hit = (tx_valid === 1'b1);
        default: hit = (busy === 1'b0);
      endcase
      if (!hit) @(negedge CLOCK_50);
    end
    check(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int base;
    int bad;
    int gap;
    bit found;

    tick(3);
    check("reset_outputs", {busy, acquire, tx_valid, overflow, run_byte, tx_byte}, '0);
    reset = 1'b0;
    tick(2);

    // Single run: 8'hA5, dynamics high at k = 0, 3, 7.
    dyn_mask = 8'b1001_0001;
    base = acq_bytes.size();
    push(8'hA5);
    wait_until("s1_acquire", 0, 10);
    check("s1_run_byte", run_byte, 8'hA5);
    wait_until("s1_tx_valid", 1, 300);
    check("s1_tx_byte", tx_byte, 8'h91);
    wait_until("s1_idle", 2, 4000);
    check("s1_acquire_count", acq_bytes.size() - base, 1);

    // Downstream stalls for 5000 cycles.
    dyn_mask = 8'h5A;
    tx_ready = 1'b0;
    base = acq_bytes.size();
    push(8'h3C);
    wait_until("s2_acquire", 0, 10);
    check("s2_run_byte", run_byte, 8'h3C);
    wait_until("s2_tx_valid", 1, 300);
    check("s2_tx_byte", tx_byte, 8'h5A);
    bad = 0;
    repeat (5000) begin
      tick(1);
      if (tx_valid !== 1'b1 || tx_byte !== 8'h5A || acquire !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("s2_hold_violations", bad, 0);
    tx_ready = 1'b1;
    tick(1);
    check("s2_drain_busy_txv", {busy, tx_valid}, 2'b10);
    tick(1);
    check("s2_back_idle", busy, 1'b0);
    check("s2_acquire_count", acq_bytes.size() - base, 1);

    // Reset at cnt = 100 with one byte still queued.
    dyn_mask = 8'h00;
    push(8'h11);
    wait_until("s5_acquire", 0, 10);
    push(8'h22);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (since_acq == 100) found = 1'b1;
      else tick(1);
    end
    check("s5_reached_cnt100", 32'(found), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("s5_reset_outputs", {busy, acquire, tx_valid, overflow, run_byte, tx_byte}, '0);
    @(negedge CLOCK_50);
    reset = 1'b0;
    base = acq_bytes.size();
    tick(20);
    check("s5_pending_lost", acq_bytes.size() - base, 0);
    dyn_mask = 8'hC3;
    push(8'h77);
    wait_until("s5_relaunch", 0, 10);
    check("s5_run_byte", run_byte, 8'h77);
    wait_until("s5_tx_valid", 1, 300);
    check("s5_tx_byte", tx_byte, 8'hC3);
    wait_until("s5_idle", 2, 4000);

    // Six back-to-back bytes while busy: one launches, four queue, the sixth drops.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    dyn_mask = 8'h0F;
    base = acq_bytes.size();
    for (int i = 1; i <= 6; i++) push(8'(i));
    check("s3_overflow", overflow, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 5 * MIN_GAP + 500 && !found; i++) begin
      if (acq_bytes.size() - base >= 5) found = 1'b1;
      else tick(1);
    end
    check("s3_five_launched", 32'(found), 32'd1);
    wait_until("s3_idle", 2, 4000);
    tick(10);
    check("s3_run_count", acq_bytes.size() - base, 5);
    if (acq_bytes.size() - base >= 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("s3_order_%0d", i), acq_bytes[base+i], 32'(i + 1));
      for (int i = 0; i < 4; i++) begin
        gap = acq_cycles[base+i+1] - acq_cycles[base+i];
        check($sformatf("s3_gap_%0d_ge_%0d", i, MIN_GAP), 32'(gap >= MIN_GAP), 32'd1);
      end
    end
    check("s3_tx_byte", tx_byte, 8'h0F);
    check("s3_overflow_sticky", overflow, 1'b1);

    // Push arriving in the IDLE pop cycle with the FIFO full.
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(1);
    dyn_mask = 8'h00;
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    check("s4_full_count", dut.u_fifo.count_q, 4);
    check("s4_no_overflow_yet", overflow, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      if (busy === 1'b0) found = 1'b1;
      else tick(1);
    end
    check("s4_reached_idle", 32'(found), 32'd1);
    rx_byte  = 8'h15;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
    check("s4_count_after", dut.u_fifo.count_q, 4);
    check("s4_overflow", overflow, 1'b0);
    check("s4_acquire", acquire, 1'b1);
    check("s4_run_byte", run_byte, 8'h11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
